// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: valid/ready handshake, one-entry skid buffer, synchronous flush.
// Optional stall counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_stage #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_zero,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_fwd_b,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_zero,
    output logic [REG_W-1:0]  out_rd,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_fwd_b,
    output logic [DATA_W-1:0] out_pc
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              zero;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] fwd_b;
        logic [DATA_W-1:0] pc;
    } entry_t;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_ent;
    logic   accept, drain;

    assign in_ent   = '{ctrl: in_ctrl, zero: in_zero, rd: in_rd,
                        alu: in_alu, fwd_b: in_fwd_b, pc: in_pc};
    assign in_ready = reset & ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid_q & out_ready;

    // Occupancy is implied by the valid bits: EMPTY, ONE (main), TWO (main + skid).
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_d       = in_ent;
            end
        end else if (!skid_valid_q) begin
            if (accept && drain) begin
                main_d = in_ent;
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_d       = in_ent;
            end else if (drain) begin
                main_valid_d = 1'b0;
            end
        end else if (drain) begin
            skid_valid_d = 1'b0;
            main_d       = skid_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    // Control is forced to zero on bubbles; data fields keep their last value.
    assign out_valid = main_valid_q;
    assign out_ctrl  = main_valid_q ? main_q.ctrl : '0;
    assign out_zero  = main_q.zero;
    assign out_rd    = main_q.rd;
    assign out_alu   = main_q.alu;
    assign out_fwd_b = main_q.fwd_b;
    assign out_pc    = main_q.pc;

`ifdef EX_MEM_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Flush deliberately leaves the counter alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX/MEM pipeline stage register with a valid/ready handshake, a one-entry skid buffer, and a synchronous flush. It sits between the execute stage and the data-memory stage. It captures the ALU result, forwarded store data, branch-target PC, zero flag, destination register and the MEM/WB control bundle. Unlike a plain edge register, it supports back-pressure from the memory stage at full throughput and guarantees that bubbles never assert memory or writeback controls.

## Interface
Parameters:
- DATA_W, 64, width of ALU result, store data and PC fields
- REG_W, 5, destination register index width
- CTRL_W, 5, control bundle width; bit order [0] Branch, [1] MemRead, [2] MemWrite, [3] RegWrite, [4] MemtoReg
- CNT_W, 32, stall counter width (used only with EX_MEM_STALL_CNT_EN)

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  execute stage presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_ctrl  input  CTRL_W  control bundle
- in_zero  input  1  ALU zero flag
- in_rd  input  REG_W  destination register
- in_alu  input  DATA_W  ALU result
- in_fwd_b  input  DATA_W  forwarded rs2 / store data
- in_pc  input  DATA_W  branch-target adder result
- out_valid  output  1  memory stage entry valid
- out_ready  input  1  memory stage consumes this cycle
- out_ctrl, out_zero, out_rd, out_alu, out_fwd_b, out_pc  output  same widths as inputs  registered entry
- stall_cnt  output  CNT_W  back-pressure cycle count (present only with EX_MEM_STALL_CNT_EN)

## Operation
- Storage: main entry (drives outputs) plus skid entry; each has a valid bit.
- State is encoded by the valid bits: EMPTY (neither valid), ONE (main only), TWO (main and skid).
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- in_ready = reset & ~skid_valid, combinational. out_valid = main_valid.
- EMPTY: accept -> ONE, main <= input.
- ONE with accept and drain -> stays ONE, main <= input.
- ONE with accept only -> TWO, skid <= input.
- ONE with drain only -> EMPTY.
- ONE with neither -> hold.
- TWO: in_ready = 0.
- TWO with drain -> ONE, main <= skid.
- TWO without drain -> hold.
- flush = 1 has priority over everything and gives EMPTY next cycle. An input accepted in the same cycle is discarded. A drain in the same cycle still completes downstream.
- Bubble gating: out_ctrl = main_valid ? main_ctrl : 0, so Branch, MemRead, MemWrite and RegWrite are never 1 with out_valid = 0.
- Data fields are not gated. They hold their last value when invalid.
- Entry order is strictly FIFO, and no entry is ever duplicated or dropped (except by flush).

## Timing
- Latency: in_valid accepted at edge N appears on the outputs after edge N; out_valid is 1 in cycle N+1.
- Throughput: 1 entry per cycle while out_ready = 1.
- in_ready drops the cycle after the skid entry fills, never combinationally from out_ready.
- Reset asserted (reset = 0), taking effect immediately:
  - both valid bits = 0, all payload registers = 0, stall_cnt = 0
  - out_valid = 0, out_ctrl = 0, in_ready = 0
- First accept is possible on the first rising edge after reset deasserts.
- Reset mid-operation loses all held entries, with no partial update.
- Simultaneous flush and reset: reset wins.

## Configuration
- EX_MEM_STALL_CNT_EN defined:
  - stall_cnt port and counter are present.
  - The counter increments on each cycle with out_valid = 1 and out_ready = 0.
  - It saturates at all-ones.
  - It is cleared only by reset, not by flush.
- Undefined: the port and counter are absent. Handshake behaviour is identical in both builds.

## Test plan
- Reset/idle:
  - Stimulus: hold reset = 0 with in_valid = 1, in_ctrl = 5'b11111.
  - Required: out_valid = 0, out_ctrl = 0, in_ready = 0, out_alu = 0.
  - Then release reset.
  - Required: the first accept appears at the outputs one cycle later.
- Streaming:
  - Stimulus: out_ready = 1; accept in_alu = 1, 2, 3, 4 on consecutive cycles.
  - Required: out_alu = 1, 2, 3, 4 on consecutive cycles, out_valid continuously 1, in_ready never 0.
- Back-pressure/skid:
  - Stimulus: send in_alu = 0xA, 0xB, 0xC with out_ready = 0.
  - Required:
    - 0xA is held on the outputs and 0xB goes to skid.
    - in_ready = 0, so 0xC is held upstream.
    - On out_ready = 1, outputs present 0xA, 0xB, 0xC in order with no loss.
    - With EX_MEM_STALL_CNT_EN, stall_cnt equals the number of stalled cycles.
- Flush in TWO:
  - Stimulus: fill both entries, then assert flush with in_valid = 1.
  - Required: next cycle out_valid = 0, out_ctrl = 0, in_ready = 1, and the flushed-cycle input never appears.
- Bubble gating:
  - Stimulus: drain to EMPTY after an entry with in_ctrl = 5'b01100.
  - Required: out_ctrl = 0 while out_alu retains the previous value.
- Counter saturation:
  - Stimulus: build with CNT_W = 4 and EX_MEM_STALL_CNT_EN, then stall 20 cycles.
  - Required: stall_cnt = 15, and it stays 15.
